// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, configurable width/parity/stop bits,
// valid/ready delivery with per-word framing/parity flags and an overrun pulse.
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CntHalf  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CntLast  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bidx_q, bidx_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_q, perr_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q, overrun_d;
    logic                  s_in, done, load, par_x;

    assign s_in  = sync_q[1];
    assign par_x = (^shreg_q) ^ s_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        done    = 1'b0;
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!s_in) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_d  = '0;
                        bidx_d = '0;
                        ferr_d = 1'b0;
                        perr_d = 1'b0;
                        state_d = s_in ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        shreg_d = {s_in, shreg_q[DATA_BITS-1:1]};
                        bidx_d  = bidx_q + 1'b1;
                        if (bidx_q == DataLast) begin
                            bidx_d  = '0;
                            state_d = (PARITY != 0) ? StParity : StStop;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        perr_d  = (PARITY == 1) ? ~par_x : par_x;
                        state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (!s_in) ferr_d = 1'b1;
                        if (bidx_q == StopLast) begin
                            done    = 1'b1;
                            state_d = s_in ? StIdle : StBreak;
                        end else begin
                            bidx_d = bidx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (s_in) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A held, unconsumed word wins over a newly completed frame.
    always_comb begin
        load         = done && (!rx_valid_q || rx_ready);
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = done && !load;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (load) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shreg_q;
            frame_err_d  = ferr_q | ~s_in;
            parity_err_d = perr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shreg_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], serial_in};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            shreg_q      <= shreg_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule
